// File: rtl/bram_rd_arbiter_if.sv
// Bus bundle between the BRAM read arbiter (slave modport) and its requesters/BRAM port (master modport).
interface bram_rd_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_rdy;
    logic                      bram_enb;
    logic [ADDR_W-1:0]         bram_addrb;
    logic [DATA_WIDTH-1:0]     bram_dout;
    logic [NUM_REQ-1:0]        rsp_vld;
    logic [DATA_WIDTH-1:0]     rsp_data;

    modport slave (
        input  req_vld, req_addr, req_lock, bram_dout,
        output req_rdy, bram_enb, bram_addrb, rsp_vld, rsp_data
    );

    modport master (
        output req_vld, req_addr, req_lock, bram_dout,
        input  req_rdy, bram_enb, bram_addrb, rsp_vld, rsp_data
    );
endinterface

// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters, with a tag pipeline routing data back.
// Define ARB_BURST_LOCK_EN to let a requester pin the grant with req_lock (LOCK state).
module bram_rd_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 2
) (
    input logic              clk,
    input logic              rst,
    bram_rd_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

`ifdef ARB_BURST_LOCK_EN
    typedef enum logic [1:0] {IDLE, ARB, LOCK} state_t;
`else
    typedef enum logic {IDLE, ARB} state_t;
`endif

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_c;
    logic                found_c;
    logic                acc_c;
    logic [NUM_REQ-1:0]  grant_c;
    logic [ADDR_W-1:0]   addr_c;
    tag_t                tag_q [RD_LATENCY];
    tag_t                tag_out_c;

`ifdef ARB_BURST_LOCK_EN
    logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
`else
    logic                lock_unused_c;
    assign lock_unused_c = ^bus.req_lock;
`endif

    // Grant selection: locked owner first, otherwise first requester at or after ptr.
    always_comb begin
        int unsigned      j;
        logic [IDX_W-1:0] j_idx;
        found_c = 1'b0;
        gidx_c  = '0;
        j       = 0;
        j_idx   = '0;
`ifdef ARB_BURST_LOCK_EN
        if (state_q == LOCK && bus.req_vld[lock_idx_q] && bus.req_lock[lock_idx_q]) begin
            found_c = 1'b1;
            gidx_c  = lock_idx_q;
        end
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j     = (32'(ptr_q) + k) % NUM_REQ;
            j_idx = IDX_W'(j);
            if (!found_c && bus.req_vld[j_idx]) begin
                found_c = 1'b1;
                gidx_c  = j_idx;
            end
        end
        acc_c   = found_c & ~rst;
        grant_c = acc_c ? (NUM_REQ'(1) << gidx_c) : '0;
        addr_c  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) addr_c = addr_c | bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
`ifdef ARB_BURST_LOCK_EN
        lock_idx_d = lock_idx_q;
`endif
        case (state_q)
            IDLE:    if (|bus.req_vld) state_d = ARB;
            ARB:     if (!(|bus.req_vld)) state_d = IDLE;
`ifdef ARB_BURST_LOCK_EN
            LOCK:    state_d = (|bus.req_vld) ? ARB : IDLE;
`endif
            default: state_d = IDLE;
        endcase
        // While locked ptr is already owner+1, so the normal update leaves it frozen.
        if (acc_c) begin
            ptr_d = (gidx_c == LAST_IDX) ? '0 : gidx_c + IDX_W'(1);
`ifdef ARB_BURST_LOCK_EN
            if (bus.req_lock[gidx_c]) begin
                state_d    = LOCK;
                lock_idx_d = gidx_c;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
`ifdef ARB_BURST_LOCK_EN
            lock_idx_q <= '0;
`endif
            for (int unsigned i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef ARB_BURST_LOCK_EN
            lock_idx_q <= lock_idx_d;
`endif
            tag_q[0] <= {acc_c, gidx_c};
            for (int unsigned i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Response routing: the oldest tag selects which requester sees bram_dout.
    always_comb begin
        tag_out_c      = tag_q[RD_LATENCY-1];
        bus.req_rdy    = grant_c;
        bus.bram_enb   = acc_c;
        bus.bram_addrb = addr_c;
        bus.rsp_vld    = '0;
        bus.rsp_data   = '0;
        if (tag_out_c.vld && !rst) begin
            bus.rsp_vld  = NUM_REQ'(1) << tag_out_c.idx;
            bus.rsp_data = bus.bram_dout;
        end
    end
endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed + random bench for bram_rd_arbiter: two instances (RD_LATENCY 2 and 1) share stimulus.
module tb_bram_rd_arbiter;
    localparam int N = 4;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   ptr_m;
    bit   locked_m;
    int   lg_m;
    logic [15:0] addr_t [N];
    logic [15:0] p2 [2];
    logic [15:0] p1;
    exp_t q2[$];
    exp_t q1[$];

    bram_rd_arbiter_if #(.NUM_REQ(N), .ADDR_W(16), .DATA_WIDTH(8)) if2 ();
    bram_rd_arbiter_if #(.NUM_REQ(N), .ADDR_W(16), .DATA_WIDTH(8)) if1 ();

    bram_rd_arbiter #(.NUM_REQ(N), .ADDR_W(16), .DATA_WIDTH(8), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(if2));
    bram_rd_arbiter #(.NUM_REQ(N), .ADDR_W(16), .DATA_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1));

    function automatic logic [7:0] memf(input logic [15:0] a);
        return 8'(a * 16'd37) ^ a[15:8] ^ 8'hA5;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: data appears RD_LATENCY cycles after the address.
    always @(posedge clk) begin
        p2[0] <= if2.bram_addrb;
        p2[1] <= p2[0];
        p1    <= if1.bram_addrb;
    end
    assign if2.bram_dout = memf(p2[1]);
    assign if1.bram_dout = memf(p1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v, input logic [3:0] lk);
`ifdef ARB_BURST_LOCK_EN
        if (locked_m && v[lg_m] && lk[lg_m]) return lg_m;
`else
        if (lk === 4'hx) return -1;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic exp_rsp(input int which, output logic [3:0] ev, output logic [7:0] ed);
        exp_t e;
        ev = '0;
        ed = '0;
        if (which == 2) begin
            if (q2.size() > 0 && q2[0].due == cyc) begin
                e = q2.pop_front(); ev = 4'(1 << e.idx); ed = e.data;
            end
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front(); ev = 4'(1 << e.idx); ed = e.data;
            end
        end
    endtask

    // One clock cycle: apply inputs, check responses and grant, update the model.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] lk);
        logic [3:0]  ev;
        logic [7:0]  ed;
        logic [63:0] pa;
        int          g;
        for (int i = 0; i < N; i++) pa[i*16 +: 16] = addr_t[i];
        rst = r;
        if2.req_vld = v;  if1.req_vld = v;
        if2.req_lock = lk; if1.req_lock = lk;
        if2.req_addr = pa; if1.req_addr = pa;
        #1;
        if (r) begin
            q2.delete();
            q1.delete();
        end
        exp_rsp(2, ev, ed);
        chk("L2.rsp_vld", 32'(if2.rsp_vld), 32'(ev));
        chk("L2.rsp_data", 32'(if2.rsp_data), 32'(ed));
        exp_rsp(1, ev, ed);
        chk("L1.rsp_vld", 32'(if1.rsp_vld), 32'(ev));
        chk("L1.rsp_data", 32'(if1.rsp_data), 32'(ed));
        g = r ? -1 : model_grant(v, lk);
        chk("L2.req_rdy", 32'(if2.req_rdy), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk("L1.req_rdy", 32'(if1.req_rdy), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk("L2.bram_enb", 32'(if2.bram_enb), (g >= 0) ? 32'd1 : 32'd0);
        chk("L2.bram_addrb", 32'(if2.bram_addrb), (g >= 0) ? 32'(addr_t[g]) : 32'd0);
        chk("L1.bram_addrb", 32'(if1.bram_addrb), (g >= 0) ? 32'(addr_t[g]) : 32'd0);
        if (g >= 0) begin
            q2.push_back('{idx: g, data: memf(addr_t[g]), due: cyc + 2});
            q1.push_back('{idx: g, data: memf(addr_t[g]), due: cyc + 1});
            ptr_m    = (g + 1) % N;
            locked_m = (lk[g] == 1'b1);
            lg_m     = g;
        end else begin
            locked_m = 1'b0;
        end
        if (r) begin
            ptr_m    = 0;
            locked_m = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, 4'b0000);
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_fail = 0; ptr_m = 0; locked_m = 1'b0; lg_m = 0;
        for (int i = 0; i < N; i++) addr_t[i] = 16'(i + 1);

        // Reset with requests pending: nothing may be granted.
        drive(1'b1, 4'b1111, 4'b0000);
        drive(1'b1, 4'b1111, 4'b0000);

        // All four requesting: 0,1,2,3,0,1,2,3.
        addr_t[0] = 16'h10; addr_t[1] = 16'h20; addr_t[2] = 16'h30; addr_t[3] = 16'h40;
        for (int i = 0; i < 8; i++) drive(1'b0, 4'b1111, 4'b0000);
        idle(3);

        // Single requester 2, addresses 5..9, granted every cycle.
        for (int i = 0; i < 5; i++) begin
            addr_t[2] = 16'(5 + i);
            drive(1'b0, 4'b0100, 4'b0000);
        end
        idle(3);

        // ptr is 3: 1001 -> 3, 0, 3.
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b1001, 4'b0000);
        idle(2);

        // Requester 2 drops before being granted; then reset right after a grant to 1.
        drive(1'b0, 4'b0110, 4'b0000);
        drive(1'b0, 4'b0010, 4'b0000);
        drive(1'b1, 4'b0000, 4'b0000);
        idle(4);
        drive(1'b0, 4'b1111, 4'b0000);
        idle(3);

        // Burst lock by requester 1 (ptr is 1).
        addr_t[0] = 16'h100; addr_t[1] = 16'h111; addr_t[2] = 16'h122; addr_t[3] = 16'h133;
        for (int i = 0; i < 4; i++) drive(1'b0, 4'b1111, 4'b0010);
        drive(1'b0, 4'b1111, 4'b0000);
        idle(3);

        // Alternating requesters 0 and 1.
        for (int i = 0; i < 6; i++) begin
            addr_t[i % 2] = 16'(16'h200 + i);
            drive(1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0010, 4'b0000);
        end
        idle(3);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) addr_t[k] = 16'($urandom);
            drive(1'b0, 4'($urandom), 4'($urandom));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
